modular_multiplier: RTL and testbench

- Pipelined Barrett modular multiplier, 30-bit operands, selectable from the team's table of 13 NTT primes.
- Sits directly upstream of modular_subtractor and the modular adder in the Cooley-Tukey butterfly: computes w*b mod q, which feeds their b input.
- Modulus selection uses the same mod_sel/mod_index protocol as the adder and subtractor, so one controller drives all three.

---
 rtl/ntt_params_pkg.sv | 22 ++
 rtl/barrett_reducer.sv | 49 ++++
 rtl/modular_multiplier.sv | 76 +++++++
 tb/tb_modular_multiplier.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ntt_params_pkg.sv
// ntt_params_pkg: NTT prime table and Barrett constants shared by the modular adder, subtractor and multiplier.
package ntt_params_pkg;
  localparam int WIDTH      = 30;
  localparam int NUM_MODULI = 13;
  localparam int IDX_W      = 4;
  localparam logic [WIDTH-1:0] MODULI [NUM_MODULI] = '{
    30'd1063321601, 30'd1063452673, 30'd1064697857, 30'd1065484289,
    30'd1065811969, 30'd1068236801, 30'd1068433409, 30'd1068564481,
    30'd1069219841, 30'd1070727169, 30'd1071513601, 30'd1072496641,
    30'd1073479681
  };
  function automatic logic [WIDTH:0] calc_mu(input logic [WIDTH-1:0] q);
    return (WIDTH+1)'((64'd1 << (2*WIDTH)) / {34'd0, q});
  endfunction
  // floor(2^60 / q), evaluated at elaboration
  localparam logic [WIDTH:0] BARRETT_MU [NUM_MODULI] = '{
    calc_mu(MODULI[0]),  calc_mu(MODULI[1]),  calc_mu(MODULI[2]),  calc_mu(MODULI[3]),
    calc_mu(MODULI[4]),  calc_mu(MODULI[5]),  calc_mu(MODULI[6]),  calc_mu(MODULI[7]),
    calc_mu(MODULI[8]),  calc_mu(MODULI[9]),  calc_mu(MODULI[10]), calc_mu(MODULI[11]),
    calc_mu(MODULI[12])
  };
endpackage

// File: rtl/barrett_reducer.sv
// barrett_reducer: three-stage Barrett reduction of a 60-bit product, r = p mod q.
module barrett_reducer
  import ntt_params_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH:0]       mu,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     r
);
  logic [2*WIDTH+1:0] pm;
  logic [2*WIDTH:0]   tq;
  logic [WIDTH:0]     t2;
  logic [WIDTH+1:0]   p2, r3, r_a, r_b;
  logic [WIDTH-1:0]   q2, q3;
  logic               v2, v3;
  always_comb begin
    pm  = {(WIDTH+1)'(0), p[2*WIDTH-1:WIDTH-1]} * {(WIDTH+1)'(0), mu};
    tq  = {WIDTH'(0), t2} * {(WIDTH+1)'(0), q2};
    r_a = r3 >= {2'b0, q3} ? r3 - {2'b0, q3} : r3;
    r_b = r_a >= {2'b0, q3} ? r_a - {2'b0, q3} : r_a;
  end
  // only the low 32 bits matter in S3 since the true remainder is below 3q < 2^32
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      t2        <= '0;
      p2        <= '0;
      q2        <= '0;
      r3        <= '0;
      q3        <= '0;
      r         <= '0;
    end else begin
      v2        <= in_valid;
      v3        <= v2;
      out_valid <= v3;
      t2        <= (WIDTH+1)'(pm >> (WIDTH+1));
      p2        <= p[WIDTH+1:0];
      q2        <= q;
      r3        <= p2 - (WIDTH+2)'(tq);
      q3        <= q2;
      if (v3) r <= WIDTH'(r_b);
    end
endmodule

// File: rtl/modular_multiplier.sv
// modular_multiplier: 4-stage pipelined Barrett (a*b) mod q over the NTT prime table.
// Optional MODMUL_INPUT_CHECK_EN adds range_err and zeroes c for out-of-range operands.
module modular_multiplier
  import ntt_params_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mod_sel,
  input  logic [IDX_W-1:0] mod_index,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c
`ifdef MODMUL_INPUT_CHECK_EN
  ,
  output logic             range_err
`endif
);
  logic [WIDTH-1:0]   q_r, q1, r;
  logic [WIDTH:0]     mu_r, mu1;
  logic [2*WIDTH-1:0] p1;
  logic               v1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_r  <= MODULI[0];
      mu_r <= BARRETT_MU[0];
    end else if (mod_sel && mod_index < IDX_W'(NUM_MODULI)) begin
      q_r  <= MODULI[mod_index];
      mu_r <= BARRETT_MU[mod_index];
    end
  // the modulus is captured with each operand so later mod_sel loads never touch it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1  <= 1'b0;
      p1  <= '0;
      q1  <= '0;
      mu1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p1  <= {WIDTH'(0), a} * {WIDTH'(0), b};
        q1  <= q_r;
        mu1 <= mu_r;
      end
    end
  barrett_reducer u_red (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .p        (p1),
    .q        (q1),
    .mu       (mu1),
    .out_valid(out_valid),
    .r        (r)
  );
`ifdef MODMUL_INPUT_CHECK_EN
  logic       e1;
  logic [1:0] es, vs;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e1        <= 1'b0;
      es        <= '0;
      vs        <= '0;
      range_err <= 1'b0;
    end else begin
      e1        <= in_valid && (a >= q_r || b >= q_r);
      es        <= {es[0], e1};
      vs        <= {vs[0], v1};
      range_err <= vs[1] ? es[1] : range_err;
    end
  assign c = range_err ? '0 : r;
`else
  assign c = r;
`endif
endmodule

// File: tb/tb_modular_multiplier.sv
// tb_modular_multiplier: directed plus random checks of modular_multiplier against a queue-based arithmetic model.
module tb_modular_multiplier;
  logic        clk = 1'b0, rst = 1'b1, mod_sel = 1'b0, in_valid = 1'b0;
  logic [3:0]  mod_index = '0;
  logic [29:0] a = '0, b = '0;
  logic        out_valid;
  logic [29:0] c;
`ifdef MODMUL_INPUT_CHECK_EN
  logic        range_err;
`endif
  always #5 clk = ~clk;
  modular_multiplier dut (
    .clk(clk), .rst(rst), .mod_sel(mod_sel), .mod_index(mod_index),
    .in_valid(in_valid), .a(a), .b(b), .out_valid(out_valid), .c(c)
`ifdef MODMUL_INPUT_CHECK_EN
    , .range_err(range_err)
`endif
  );
  localparam longint unsigned QT [13] = '{
    1063321601, 1063452673, 1064697857, 1065484289, 1065811969, 1068236801, 1068433409,
    1068564481, 1069219841, 1070727169, 1071513601, 1072496641, 1073479681
  };
  int checks = 0, fails = 0;
  longint unsigned exp_c[$], outs[$];
  bit exp_e[$], exp_dc[$];
  bit [3:0] vp;
  longint unsigned qm, last_c;
  bit last_e;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask
  // model: results are plain (a*b) % q with the modulus in force when the operand was taken
  always @(posedge clk or posedge rst)
    if (rst) begin
      vp <= '0;
      qm <= QT[0];
      exp_c.delete();
      exp_e.delete();
      exp_dc.delete();
    end else begin
      vp <= {vp[2:0], in_valid};
      if (in_valid) begin
        automatic bit oor = (a >= qm) || (b >= qm);
        automatic longint unsigned prod = (longint'(a) * longint'(b)) % qm;
`ifdef MODMUL_INPUT_CHECK_EN
        exp_c.push_back(oor ? 0 : prod);
        exp_e.push_back(oor);
        exp_dc.push_back(1'b0);
`else
        exp_c.push_back(prod);
        exp_e.push_back(1'b0);
        exp_dc.push_back(oor);
`endif
      end
      if (mod_sel && mod_index < 13) qm <= QT[mod_index];
    end
  always @(negedge clk) begin
    if (rst) begin
      last_c = 0;
      last_e = 0;
    end
    chk("out_valid", out_valid, vp[3]);
    if (vp[3] && out_valid) begin
      if (exp_c.size() == 0) chk("result_queue_empty", 1, 0);
      else begin
        automatic longint unsigned ec = exp_c.pop_front();
        automatic bit ee = exp_e.pop_front();
        automatic bit dc = exp_dc.pop_front();
        if (!dc) chk("c", c, ec);
        last_c = dc ? c : ec;
        last_e = ee;
        outs.push_back(c);
`ifdef MODMUL_INPUT_CHECK_EN
        chk("range_err", range_err, ee);
`endif
      end
    end else begin
      chk("c_hold", c, last_c);
`ifdef MODMUL_INPUT_CHECK_EN
      chk("range_err_hold", range_err, last_e);
`endif
    end
  end
  task automatic cyc(input bit s, input int idx, input bit v, input longint unsigned aa, input longint unsigned bb);
    @(negedge clk);
    mod_sel   = s;
    mod_index = 4'(idx);
    in_valid  = v;
    a         = 30'(aa);
    b         = 30'(bb);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    cyc(0, 0, 1, QT[0] - 1, QT[0] - 1);
    cyc(0, 0, 1, 100, 23);
    cyc(0, 0, 1, 0, 777);
    cyc(0, 0, 1, 2, 531660801);
    for (int i = 0; i < 13; i++) begin
      cyc(1, i, 0, 0, 0);
      cyc(0, 0, 1, QT[i] - 1, 2);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, QT[0] - 1, QT[0] - 1);
    cyc(1, 12, 1, 3, 5);
    cyc(0, 0, 1, QT[12] - 1, QT[12] - 1);
    cyc(1, 0, 1, 1063321600, 1063321600);
    cyc(0, 0, 1, 1063321600, 1063321600);
    cyc(1, 12, 0, 0, 0);
    idle(6);
    cyc(0, 0, 1, 5, 7);
    idle(1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    idle(6);
    cyc(0, 0, 1, QT[0] - 1, QT[0] - 1);
    cyc(1, 5, 0, 0, 0);
    cyc(1, 13, 0, 0, 0);
    cyc(0, 0, 1, 1068236800, 1068236800);
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 1063321600), $urandom_range(0, 1063321600));
`ifdef MODMUL_INPUT_CHECK_EN
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1063321601, 5);
    cyc(0, 0, 1, 6, 7);
`endif
    idle(8);
    chk("drain", exp_c.size(), 0);
    chk("lit_wrap_square", outs[0], 1);
    chk("lit_100x23", outs[1], 2300);
    chk("lit_zero", outs[2], 0);
    chk("lit_2x531660801", outs[3], 1);
    chk("lit_idx0_qm2", outs[4], 1063321599);
    chk("lit_idx12_qm2", outs[16], 1073479679);
    chk("lit_cross_first", outs[17], 1);
    chk("lit_cross_second", outs[18], 15);
    chk("lit_q12_square", outs[19], 1);
    chk("lit_after_reset_q0", outs[22], 1);
    chk("lit_bad_index_kept", outs[23], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
